// File: rtl/ifstage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifstage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_ROOM,
    DROP
  } if_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned IQ_DEPTH    = 2;
  localparam int unsigned IQ_CNT_W    = $clog2(IQ_DEPTH + 1);

  localparam logic [31:0] PC_ALIGN_MASK = ~32'(INSTR_BYTES - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

  // Branch target relative to the instruction following the branch.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [31:0] immed);
    return (pc + 32'(INSTR_BYTES) + (immed << 2)) & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifstage_instr_queue.sv
// Small FIFO of fetched {pc, instr} pairs; entry 0 is always the head.
module instr_queue
  import ifstage_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                push_i,
  input  logic [31:0]         push_pc_i,
  input  logic [31:0]         push_instr_i,
  input  logic                pop_i,
  input  logic                clear_i,
  output logic [IQ_CNT_W-1:0] count_o,
  output logic [31:0]         head_pc_o,
  output logic [31:0]         head_instr_o
);

  iq_entry_t           ent_q [IQ_DEPTH];
  iq_entry_t           ent_d [IQ_DEPTH];
  logic [IQ_CNT_W-1:0] cnt_q, cnt_d;
  logic [IQ_CNT_W-1:0] slot;
  logic                do_pop, do_push;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != IQ_CNT_W'(IQ_DEPTH)) || do_pop);
    slot    = cnt_q - IQ_CNT_W'(do_pop);
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else begin
      // Shift toward the head on pop, then write the push into the first free slot.
      if (do_pop) begin
        for (int unsigned i = 0; i + 1 < IQ_DEPTH; i++) begin
          ent_d[i] = ent_q[i+1];
        end
      end
      if (do_push) begin
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
          if (IQ_CNT_W'(i) == slot) begin
            ent_d[i] = '{pc: push_pc_i, instr: push_instr_i};
          end
        end
      end
      cnt_d = cnt_q + IQ_CNT_W'(do_push) - IQ_CNT_W'(do_pop);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

  assign count_o      = cnt_q;
  assign head_pc_o    = ent_q[0].pc;
  assign head_instr_o = ent_q[0].instr;

endmodule

// File: rtl/ifstage.sv
// Instruction fetch stage: fetch PC, memory req/rdy handshake, 2-entry
// instruction queue feeding DECODE, and branch redirect handling.
module ifstage
  import ifstage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Redirect,
  input  logic [31:0] Immed,
  input  logic        Instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic        Instr_valid,
  output logic        Mem_req,
  output logic [31:0] Mem_addr,
  input  logic        Mem_rdy,
  input  logic [31:0] Mem_rdata
);

  if_state_e           state_q, state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic [31:0]         drop_addr_q, drop_addr_d;
  logic [IQ_CNT_W-1:0] iq_count, count_after;
  logic [31:0]         target;
  logic                redir, push, pop;

  assign Instr_valid = (iq_count != '0);
  assign redir       = Redirect && Instr_valid;
  assign pop         = Instr_valid && Instr_ready;
  assign push        = (state_q == FETCH) && Mem_rdy && !redir;
  assign count_after = iq_count + IQ_CNT_W'(push) - IQ_CNT_W'(pop);
  assign target      = branch_target(Instr_PC, Immed);

  instr_queue u_queue (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .push_i       (push),
    .push_pc_i    (fetch_pc_q),
    .push_instr_i (Mem_rdata),
    .pop_i        (pop),
    .clear_i      (redir),
    .count_o      (iq_count),
    .head_pc_o    (Instr_PC),
    .head_instr_o (Instr)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redir) begin
          state_d = Mem_rdy ? FETCH : DROP;
        end else if (Mem_rdy && (count_after == IQ_CNT_W'(IQ_DEPTH))) begin
          state_d = WAIT_ROOM;
        end
      end
      WAIT_ROOM: if (redir || pop) state_d = FETCH;
      DROP:      if (Mem_rdy) state_d = FETCH;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    Mem_req  = 1'b0;
    Mem_addr = fetch_pc_q;
    unique case (state_q)
      FETCH: Mem_req = 1'b1;
      DROP: begin
        Mem_req  = 1'b1;
        Mem_addr = drop_addr_q;
      end
      default: Mem_req = 1'b0;
    endcase
  end

  // A redirect mid-wait keeps the stale address on the bus until memory completes it.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    if (redir) begin
      fetch_pc_d = target;
      if ((state_q == FETCH) && !Mem_rdy) begin
        drop_addr_d = fetch_pc_q;
      end
    end else if ((state_q == FETCH) && Mem_rdy) begin
      fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_pc_q  <= RESET_PC & PC_ALIGN_MASK;
      drop_addr_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

endmodule

// File: doc/ifstage.md
# ifstage

Instruction fetch stage sitting directly upstream of DECODE. It holds the fetch PC, issues word reads to instruction memory over a req/rdy handshake, and buffers returned words with their PCs in a 2-entry queue. Its head entry drives DECODE's `Instr` input. It also accepts branch redirects computed from DECODE's sign-extended `Immed`.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; word aligned.
- `Clk` in 1: rising-edge clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Redirect` in 1: the branch at the head entry is taken this cycle; qualified by `Instr_valid`.
- `Immed` in 32: sign-extended immediate from DECODE, used for the branch target.
- `Instr_ready` in 1: DECODE consumes the head entry when `Instr_valid & Instr_ready`.
- `Instr` out 32: instruction word of the head entry.
- `Instr_PC` out 32: PC of the head entry.
- `Instr_valid` out 1: the queue is non-empty.
- `Mem_req` out 1: memory read request.
- `Mem_addr` out 32: read address, word aligned.
- `Mem_rdy` in 1: memory completes the request this cycle.
- `Mem_rdata` in 32: read data, valid when `Mem_req & Mem_rdy`.

## Operation
- **State machine states:** IDLE, FETCH, WAIT_ROOM, DROP.
- **IDLE:** the reset state. Moves to FETCH on the next cycle unconditionally.
- **FETCH:**
  - `Mem_req`=1 and `Mem_addr`=fetch_pc.
  - On `Mem_rdy`: push {fetch_pc, `Mem_rdata`} and set fetch_pc += 4.
  - If the resulting count is 2, go to WAIT_ROOM; otherwise stay in FETCH.
- **WAIT_ROOM:**
  - `Mem_req`=0.
  - Go to FETCH in the cycle after a pop occurs.
- **DROP:**
  - `Mem_req`=1 and `Mem_addr` = the old, held address.
  - On `Mem_rdy`: discard the data and go to FETCH.
- **Handshake rule:** while `Mem_req & !Mem_rdy`, `Mem_addr` is stable. A request is never withdrawn before `Mem_rdy`.
- **Queue:** 2 entries {pc, instr}, FIFO order.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push never occurs when the queue is full; the FSM guarantees this.
- **Redirect:** takes effect only when `Redirect & Instr_valid`.
  - target = `Instr_PC` + 4 + (`Immed` << 2), modulo 2^32.
  - The queue is cleared, including any pop that coincides with the redirect.
  - fetch_pc <= target.
  - If in FETCH with `Mem_rdy`=1: the returned word is discarded; stay in FETCH at the target.
  - If in FETCH with `Mem_rdy`=0: go to DROP.
  - If in WAIT_ROOM: go to FETCH.
  - If in IDLE or DROP: the state is unchanged.
- `Redirect` is ignored when `Instr_valid`=0.
- fetch_pc wraps from 32'hFFFF_FFFC to 0.
- `Mem_addr[1:0]` is always 2'b00.

## Timing
- **Reset values** (asynchronous, immediate on `Reset_n` low):
  - state=IDLE, fetch_pc=`RESET_PC`, count=0.
  - `Mem_req`=0, `Instr_valid`=0, `Instr`=0, `Instr_PC`=0.
- **First request:** `Mem_req` rises in the second rising edge's cycle after reset release, with `Mem_addr`=`RESET_PC`.
- **Latency:** `Mem_rdy` in cycle N gives `Instr_valid` with that word in cycle N+1.
- **Throughput:** with `Mem_rdy` tied high and `Instr_ready` tied high, one instruction per cycle and no bubbles.
- **Backpressure:** a DECODE stall fills the queue. After the first pop, one idle request cycle occurs before fetch resumes.
- **Redirect:** target word appears at `Instr_valid` at the earliest 2 cycles after redirect, when memory has zero wait states. The wait is one more cycle when passing through DROP, plus memory wait states.
- **Reset mid-transaction:** any outstanding request is abandoned and the queue is emptied. Memory must tolerate `Mem_req` dropping.
- All outputs except `Mem_req` and `Mem_addr` are registered or queue-head values.
- `Mem_req` and `Mem_addr` are decoded from registered state only. They do not depend combinationally on `Mem_rdy`.

## Structure
- **Shared package `ifstage_pkg`:**
  - State enum {IDLE, FETCH, WAIT_ROOM, DROP}.
  - Constants `INSTR_BYTES`=4 and `IQ_DEPTH`=2.
- **Sub-module `instr_queue`:** a 2-entry {pc, instr} FIFO with push, pop, clear, count, and head outputs, sharing `Clk`/`Reset_n`.
- Target adder and state machine are in the top level.

## Test plan
- **Reset and streaming:**
  - Stimulus: `RESET_PC`=32'h100; zero-wait memory returning `Mem_rdata` = address; `Instr_ready`=1.
  - Response: `Instr_PC` = 100, 104, 108, ... on consecutive cycles, with `Instr`==`Instr_PC`.
- **Backpressure:**
  - Stimulus: `Instr_ready`=0 for 5 cycles.
  - Response: count stays at 2, `Mem_req`=0, and the head holds 32'h104. After release, the order is 104, 108, 10C with nothing lost and nothing duplicated.
- **Branch:**
  - Stimulus: head PC 32'h200 with `Redirect`=1 and `Immed`=32'hFFFF_FFFE.
  - Response: next `Mem_addr`=32'h1FC. Words already queued after 200 never appear.
- **Redirect during a wait-state access:**
  - Stimulus: `Mem_rdy` held low for 3 cycles while redirecting to 32'h400.
  - Response: `Mem_addr` stays at the old value until `Mem_rdy`; that word is dropped; the next request is 32'h400.
- **Wrap and ignored redirect:**
  - Stimulus A: fetch_pc 32'hFFFF_FFFC.
  - Response A: the next request is 32'h0.
  - Stimulus B: `Redirect`=1 with the queue empty.
  - Response B: no effect.
- **Asynchronous reset mid-transaction:**
  - Stimulus: `Reset_n` pulsed low between clock edges with the queue full.
  - Response: `Instr_valid` and `Mem_req` drop immediately. Fetch restarts at `RESET_PC`.
